// File: rtl/demux_dispatch_ctrl_if.sv
// Handshake bundle between the dispatch controller, its single source and its four sinks.
// The master modport is the controller's view of the bundle.
interface demux_dispatch_ctrl_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_dest;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   sel;

  modport master (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data, sel
  );

  modport slave (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data, sel
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller for the 1x4 demux: captures one word, routes it (addressed or round-robin),
// and abandons it if the target sink stalls for TIMEOUT cycles.
module demux_dispatch_ctrl #(
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  output logic                   drop_pulse,
  output logic [7:0]             drop_count,
  demux_dispatch_ctrl_if.master  bus
);
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t       state;
  state_t       next_state;
  logic [W-1:0] data_q;
  logic [1:0]   sel_q;
  logic [3:0]   valid_q;
  logic [1:0]   rr_ptr;
  logic [1:0]   target;
  logic [7:0]   wait_cnt;
  logic         capture;
  logic         deliver;
  logic         expire;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A ready sink wins over an expiring timeout in the same cycle.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    deliver    = 1'b0;
    expire     = 1'b0;
    target     = mode ? rr_ptr : bus.in_dest;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready[sel_q]) begin
          deliver    = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          expire     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      sel_q      <= 2'd0;
      valid_q    <= 4'b0000;
      rr_ptr     <= 2'd0;
      wait_cnt   <= 8'd0;
      drop_pulse <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      drop_pulse <= expire;
      if (capture) begin
        data_q   <= bus.in_data;
        sel_q    <= target;
        valid_q  <= 4'b0001 << target;
        wait_cnt <= 8'd0;
        if (mode) rr_ptr <= target + 2'd1;
      end else if (deliver || expire) begin
        valid_q <= 4'b0000;
      end else if (state == HOLD) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (expire && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.sel       = sel_q;
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Scoreboard bench for demux_dispatch_ctrl: each captured word queues its expected channel/data/drop
// outcome, and a negedge monitor retires entries as deliveries or drop strobes appear.
module tb_demux_dispatch_ctrl;
  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       drop;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       mode;
  logic       drop_pulse;
  logic [7:0] drop_count;
  int         vec_count;
  int         err_count;
  logic [1:0] model_rr;
  exp_t       exp_q[$];

  demux_dispatch_ctrl_if #(.W(8)) bus ();

  demux_dispatch_ctrl #(.W(8), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .drop_pulse (drop_pulse),
    .drop_count (drop_count),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic m, input logic [1:0] dest, input logic [7:0] data, input logic drop);
    int   guard;
    exp_t e;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("in_ready_before_capture", 32'(bus.in_ready), 32'd1);
    e.ch   = m ? model_rr : dest;
    e.data = data;
    e.drop = drop;
    if (m) model_rr = model_rr + 2'd1;
    exp_q.push_back(e);
    mode         = m;
    bus.in_dest  = dest;
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    tick();
    // Scramble the sideband while the word is in flight; it must not matter.
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    bus.in_dest  = 2'($urandom);
    mode         = 1'($urandom);
  endtask

  // Retire scoreboard entries on sink handshakes and on drop strobes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if ((bus.out_valid & bus.out_ready) != 4'b0000) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_delivery", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("deliver_not_drop", 32'd0, 32'(e.drop));
          checkOutput("deliver_sel", 32'(bus.sel), 32'(e.ch));
          checkOutput("deliver_valid", 32'(bus.out_valid), 32'(4'b0001 << e.ch));
          checkOutput("deliver_data", 32'(bus.out_data), 32'(e.data));
        end
      end
      if (drop_pulse) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_drop", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("drop_expected", 32'd1, 32'(e.drop));
        end
      end
    end
  end

  initial begin
    vec_count     = 0;
    err_count     = 0;
    model_rr      = 2'd0;
    rst           = 1'b1;
    mode          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_dest   = 2'd0;
    bus.out_ready = 4'b0000;
    tick();
    tick();
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_sel", 32'(bus.sel), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rst_drop_pulse", 32'(drop_pulse), 32'd0);
    checkOutput("rst_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_rst", 32'(bus.in_ready), 32'd1);
    tick();

    $display("[TB] addressed delivery");
    bus.out_ready = 4'b1111;
    applyStimulus(1'b0, 2'd2, 8'hA5, 1'b0);
    checkOutput("addr_out_valid", 32'(bus.out_valid), 32'h4);
    checkOutput("addr_sel", 32'(bus.sel), 32'd2);
    checkOutput("addr_out_data", 32'(bus.out_data), 32'hA5);
    checkOutput("addr_in_ready_hold", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("addr_in_ready_back", 32'(bus.in_ready), 32'd1);
    checkOutput("addr_valid_cleared", 32'(bus.out_valid), 32'd0);
    checkOutput("addr_sel_held", 32'(bus.sel), 32'd2);
    checkOutput("addr_drop_count", 32'(drop_count), 32'd0);

    $display("[TB] round-robin");
    for (int i = 0; i < 5; i++) begin
      logic [7:0] w;
      logic [1:0] ch;
      w  = 8'(8'h11 * (i + 1));
      ch = 2'(i);
      applyStimulus(1'b1, 2'd3, w, 1'b0);
      checkOutput("rr_out_valid", 32'(bus.out_valid), 32'(4'b0001 << ch));
      tick();
      checkOutput("rr_in_ready_next", 32'(bus.in_ready), 32'd1);
    end

    $display("[TB] backpressure");
    bus.out_ready = 4'b1000;
    applyStimulus(1'b0, 2'd1, 8'h3C, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_stall_valid", 32'(bus.out_valid), 32'h2);
      tick();
    end
    bus.out_ready = 4'b1010;
    checkOutput("bp_final_valid", 32'(bus.out_valid), 32'h2);
    tick();
    checkOutput("bp_done_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_drop_count", 32'(drop_count), 32'd0);

    $display("[TB] timeout");
    bus.out_ready = 4'b0000;
    applyStimulus(1'b0, 2'd0, 8'h5A, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("to_hold_valid", 32'(bus.out_valid), 32'h1);
      checkOutput("to_hold_no_pulse", 32'(drop_pulse), 32'd0);
      tick();
    end
    checkOutput("to_pulse", 32'(drop_pulse), 32'd1);
    checkOutput("to_valid_cleared", 32'(bus.out_valid), 32'd0);
    checkOutput("to_drop_count", 32'(drop_count), 32'd1);
    checkOutput("to_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("to_pulse_single", 32'(drop_pulse), 32'd0);
    bus.out_ready = 4'b1111;
    applyStimulus(1'b0, 2'd3, 8'h77, 1'b0);
    checkOutput("to_next_valid", 32'(bus.out_valid), 32'h8);
    tick();

    $display("[TB] race and saturation");
    bus.out_ready = 4'b0000;
    applyStimulus(1'b0, 2'd2, 8'h99, 1'b0);
    repeat (3) tick();
    bus.out_ready = 4'b0100;
    tick();
    checkOutput("race_no_pulse", 32'(drop_pulse), 32'd0);
    checkOutput("race_drop_count", 32'(drop_count), 32'd1);
    checkOutput("race_valid_cleared", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 4'b0000;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 2'(i), 8'(i), 1'b1);
      repeat (4) tick();
      if (i == 199) checkOutput("sat_mid_count", 32'(drop_count), 32'd201);
    end
    checkOutput("sat_count", 32'(drop_count), 32'd255);
    applyStimulus(1'b0, 2'd1, 8'hC3, 1'b1);
    repeat (4) tick();
    checkOutput("sat_pulse_still", 32'(drop_pulse), 32'd1);
    checkOutput("sat_count_held", 32'(drop_count), 32'd255);

    $display("[TB] reset mid-HOLD");
    applyStimulus(1'b0, 2'd3, 8'hE1, 1'b1);
    checkOutput("rh_valid_before", 32'(bus.out_valid), 32'h8);
    rst = 1'b1;
    exp_q.delete();
    model_rr = 2'd0;
    tick();
    checkOutput("rh_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rh_sel", 32'(bus.sel), 32'd0);
    checkOutput("rh_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("rh_drop_pulse", 32'(drop_pulse), 32'd0);
    checkOutput("rh_drop_count", 32'(drop_count), 32'd0);
    checkOutput("rh_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rh_in_ready_release", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("rh_no_late_drop", 32'(drop_pulse), 32'd0);
    end
    bus.out_ready = 4'b1111;
    applyStimulus(1'b1, 2'd3, 8'h42, 1'b0);
    checkOutput("rh_rr_first_ch0", 32'(bus.out_valid), 32'h1);
    tick();
    tick();
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end
endmodule
